// File: rtl/traffic_interval_timer_if.sv
// Control/status bundle between the traffic-light FSM (master) and the interval timer (slave).
// TIMER_STATUS_EN adds the countdown status signals used by the seven-segment display.
interface traffic_interval_timer_if;
  logic       Prog_Sync;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic [1:0] interval;
  logic       start_timer;
  logic       expired;
`ifdef TIMER_STATUS_EN
  logic [4:0] time_left;
  logic       second_tick;
`endif

  modport master (
    output Prog_Sync, Time_Parameter_Selector, Time_Value, interval, start_timer,
`ifdef TIMER_STATUS_EN
    input  time_left, second_tick,
`endif
    input  expired
  );

  modport slave (
    input  Prog_Sync, Time_Parameter_Selector, Time_Value, interval, start_timer,
`ifdef TIMER_STATUS_EN
    output time_left, second_tick,
`endif
    output expired
  );
endinterface

// File: rtl/traffic_interval_timer.sv
// Programmable seconds countdown for the traffic-light FSM: base/ext/yellow registers, divider, one-cycle expired pulse.
// Optional TIMER_STATUS_EN exposes time_left and a registered second_tick.
module traffic_interval_timer #(
  parameter int CLK_FREQ = 100000000,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input logic                    clk,
  input logic                    Reset_n,
  traffic_interval_timer_if.slave bus
);
  localparam int             DW      = $clog2(CLK_FREQ);
  localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_FREQ - 1);
  localparam logic [3:0]     D_BASE  = 4'(DEF_BASE);
  localparam logic [3:0]     D_EXT   = 4'(DEF_EXT);
  localparam logic [3:0]     D_YEL   = 4'(DEF_YEL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [3:0]    base, ext, yel;
  logic [DW-1:0] div;
  logic [4:0]    rem;
  logic [4:0]    dur;
  logic [3:0]    wval;
  logic          tick;
  logic          expired_q;
`ifdef TIMER_STATUS_EN
  logic          tick_q;
`endif

  // Duration comes from the registers as they stand before any same-cycle write.
  always_comb begin
    dur = {1'b0, base};
    case (bus.interval)
      2'b00: dur = {1'b0, base};
      2'b01: dur = {1'b0, ext};
      2'b10: dur = {1'b0, yel};
      2'b11: dur = {base, 1'b0};
      default: dur = {1'b0, base};
    endcase
  end

  // A zero write falls back to the default so no interval can ever be 0 s.
  always_comb begin
    wval = bus.Time_Value;
    if (bus.Time_Value == 4'd0) begin
      case (bus.Time_Parameter_Selector)
        2'b00:   wval = D_BASE;
        2'b01:   wval = D_EXT;
        2'b10:   wval = D_YEL;
        default: wval = bus.Time_Value;
      endcase
    end
  end

  assign tick = (state == RUN) && (div == DIV_MAX);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      base      <= D_BASE;
      ext       <= D_EXT;
      yel       <= D_YEL;
      div       <= '0;
      rem       <= '0;
      expired_q <= 1'b0;
`ifdef TIMER_STATUS_EN
      tick_q    <= 1'b0;
`endif
    end else begin
      expired_q <= 1'b0;
`ifdef TIMER_STATUS_EN
      tick_q    <= tick;
`endif
      if (bus.Prog_Sync) begin
        case (bus.Time_Parameter_Selector)
          2'b00:   base <= wval;
          2'b01:   ext  <= wval;
          2'b10:   yel  <= wval;
          default: ;
        endcase
      end
      // A start always wins, including on the edge that would otherwise expire.
      if (bus.start_timer) begin
        state <= RUN;
        rem   <= dur;
        div   <= '0;
      end else if (state == RUN) begin
        if (tick) begin
          div <= '0;
          if (rem > 5'd1) begin
            rem <= rem - 5'd1;
          end else begin
            rem       <= '0;
            expired_q <= 1'b1;
            state     <= IDLE;
          end
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  assign bus.expired = expired_q;
`ifdef TIMER_STATUS_EN
  assign bus.time_left   = rem;
  assign bus.second_tick = tick_q;
`endif
endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench: each accepted start pushes its absolute expiry cycle; a monitor pops on every expired pulse.
module tb_traffic_interval_timer;
  localparam int CF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_interval_timer_if bus();

  traffic_interval_timer #(.CLK_FREQ(CF), .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)) dut (
    .clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q[$];
  int passed = 0;
  int total  = 0;
  int mb = 6, me = 3, my = 2;

  function automatic int model_dur(int iv);
    case (iv)
      0: return mb;
      1: return me;
      2: return my;
      default: return 2 * mb;
    endcase
  endfunction

  function automatic void check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // One cycle of stimulus; sampled by the DUT at edge cyc+1.
  task automatic step(bit st, int iv, bit pg, int sel, int val);
    int e;
    @(negedge clk);
    bus.start_timer             = st;
    bus.interval                = 2'(iv);
    bus.Prog_Sync               = pg;
    bus.Time_Parameter_Selector = 2'(sel);
    bus.Time_Value              = 4'(val);
    if (st && rst_n) begin
      e = cyc + 1;
      while (q.size() > 0 && q[$] >= e) void'(q.pop_back());
      q.push_back(e + model_dur(iv) * CF);
    end
    if (pg && rst_n) begin
      case (sel)
        0: mb = (val == 0) ? 6 : val;
        1: me = (val == 0) ? 3 : val;
        2: my = (val == 0) ? 2 : val;
        default: ;
      endcase
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 0, 1'b0, 3, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    while (q.size() > 0 && q[$] > cyc) void'(q.pop_back());
    mb = 6; me = 3; my = 2;
    step(1'b1, 0, 1'b1, 0, 9);   // start and prog during reset must be ignored
    step(1'b1, 1, 1'b1, 1, 9);
    @(negedge clk);
    rst_n = 1'b1;
    bus.start_timer = 1'b0;
    bus.Prog_Sync   = 1'b0;
  endtask

  // Monitor: every expired pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    int t;
    if (rst_n) begin
      if (bus.expired) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_expired: got pulse at cycle %0d, expected none", cyc);
        end else begin
          t = q.pop_front();
          check("expiry_cycle", cyc, t);
        end
      end else if (q.size() > 0 && q[0] <= cyc) begin
        t = q.pop_front();
        total++;
        $display("FAIL missed_expiry: got no pulse, expected one at cycle %0d", t);
      end
    end
  end

  initial begin
    bus.start_timer = 1'b0;
    bus.interval = 2'b00;
    bus.Prog_Sync = 1'b0;
    bus.Time_Parameter_Selector = 2'b11;
    bus.Time_Value = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_expired", int'(bus.expired), 0);
`ifdef TIMER_STATUS_EN
    check("reset_time_left", int'(bus.time_left), 0);
    check("reset_second_tick", int'(bus.second_tick), 0);
`endif
    rst_n = 1'b1;

    // Defaults: base 24 cycles, 2*base 48 cycles
    step(1'b1, 0, 1'b0, 3, 0); idle(30);
    step(1'b1, 3, 1'b0, 3, 0); idle(55);
    // Program yellow to 5, then to 0 (falls back to default 2)
    step(1'b0, 0, 1'b1, 2, 5); step(1'b1, 2, 1'b0, 3, 0); idle(25);
    step(1'b0, 0, 1'b1, 2, 0); step(1'b1, 2, 1'b0, 3, 0); idle(12);
    // Selector 11 writes nothing
    step(1'b0, 0, 1'b1, 3, 9);
    step(1'b1, 0, 1'b0, 3, 0); idle(30);
    step(1'b1, 1, 1'b0, 3, 0); idle(15);
    step(1'b1, 2, 1'b0, 3, 0); idle(12);
    // Restart at E0+10 with ext
    step(1'b1, 0, 1'b0, 3, 0); idle(9);
    step(1'b1, 1, 1'b0, 3, 0); idle(30);
    // Start on the expiry edge: restart wins
    step(1'b1, 0, 1'b0, 3, 0); idle(23);
    step(1'b1, 1, 1'b0, 3, 0); idle(20);
    // Same-cycle program and start uses the old value
    step(1'b1, 0, 1'b1, 0, 1); idle(30);
    step(1'b1, 0, 1'b1, 0, 0); idle(30);
    // Reset mid-count abandons the countdown and restores defaults
    step(1'b0, 0, 1'b1, 1, 7);
    step(1'b1, 1, 1'b0, 3, 0); idle(8);
    reset_pulse();
`ifdef TIMER_STATUS_EN
    check("post_reset_time_left", int'(bus.time_left), 0);
`endif
    idle(40);
    step(1'b1, 1, 1'b0, 3, 0); idle(15);
    step(1'b1, 3, 1'b0, 3, 0); idle(52);

    // Randomized traffic
    repeat (1500)
      step(($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    idle(130);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
- Programmable interval timer that sits directly upstream of the traffic-light FSM.
- Stores the three time parameters (base, extended, yellow), which are reprogrammable through the Prog_Sync path.
- Decodes the FSM's interval code and start_timer pulse, counts whole seconds from a divided system clock, and returns a single-cycle expired pulse.

Parameters:
- CLK_FREQ, 100000000, clk cycles per one-second tick; must be >= 2.
- DEF_BASE, 6, reset and default value of tBASE, in seconds.
- DEF_EXT, 3, reset and default value of tEXT, in seconds.
- DEF_YEL, 2, reset and default value of tYEL, in seconds.

Ports:
- clk  in  1  system clock; all state on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Prog_Sync  in  1  synchronised program strobe; level-sensitive, write every cycle it is high.
- Time_Parameter_Selector  in  2  00=tBASE, 01=tEXT, 10=tYEL, 11=no target.
- Time_Value  in  4  new value in seconds for the selected parameter.
- interval  in  2  00=tBASE, 01=tEXT, 10=tYEL, 11=2*tBASE.
- start_timer  in  1  one-cycle request to (re)start a countdown.
- expired  out  1  one-cycle pulse at end of countdown; registered.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - base=DEF_BASE, ext=DEF_EXT, yel=DEF_YEL.
  - State IDLE; divider=0; remaining=0; expired=0.
  - Reset mid-count abandons the countdown; no expired pulse follows.
- Parameter registers are 4 bits each.
  - Prog_Sync=1 writes Time_Value to the register chosen by Time_Parameter_Selector.
  - Selector 11: no write.
  - Time_Value=0 writes the matching DEF_* value instead, so a duration is never 0.
- Duration lookup is 5 bits, combinational from the current registers:
  - 00 -> base, 01 -> ext, 10 -> yel, 11 -> {base,1'b0} (max 30).
- Same-cycle Prog_Sync write and start_timer: the duration uses the pre-write register value.
- Divider:
  - Counts 0..CLK_FREQ-1 while in RUN and holds at 0 in IDLE.
  - Cleared to 0 on any accepted start_timer.
  - tick = (divider==CLK_FREQ-1) in RUN; divider wraps to 0.
- State machine, IDLE / RUN:
  - IDLE + start_timer: remaining<=duration, divider<=0, go to RUN.
  - RUN + start_timer: restart exactly as from IDLE, discarding the current count.
  - RUN + tick with remaining>1: remaining<=remaining-1.
  - RUN + tick with remaining==1: remaining<=0, expired<=1 for one cycle, go to IDLE.
  - expired is cleared on the next edge unconditionally.
- Latency: with start_timer sampled at edge E0 and duration D, expired goes high at edge E0+D*CLK_FREQ and low one edge later.
- start_timer on the same edge that would expire: restart wins; expired stays 0 and a new countdown begins.
- Prog_Sync while running does not change the active countdown. New values apply to the next start_timer.
- start_timer is ignored while Reset_n is low.
- Implementation counters: the divider is wide enough for CLK_FREQ-1 ($clog2(CLK_FREQ) bits); remaining is 5 bits.

Optional Feature:
- Macro: TIMER_STATUS_EN.
- Defined:
  - Adds output time_left [4:0] = remaining, reset 0.
  - Adds output second_tick [0:0] = registered tick pulse, reset 0.
  - Intended for the seven-segment countdown display.
- Undefined: neither port exists; core timing behaviour is identical.

Test Plan:
- Defaults, CLK_FREQ=4: reset, then start_timer with interval=00 at edge E0 -> expired high exactly at E0+24 for one cycle; interval=11 -> E0+48.
- Programming: Prog_Sync, selector=10, value=5; then start with interval=10 -> expires at E0+20. Program value=0 into selector 10, then start -> expires at E0+8 (DEF_YEL).
- Selector 11 with Prog_Sync and value=9 -> base/ext/yel unchanged; starts with interval 00/01/10 give 24/12/8 cycles.
- Restart: start interval=00, then re-pulse start_timer with interval=01 at E0+10 -> no expired at E0+24; expired at E0+10+12=E0+22.
- Simultaneous: start_timer asserted on the expiry edge -> expired stays 0; a new full countdown completes D*4 edges later.
- Reset mid-count: Reset_n low at E0+9 for 2 cycles, then no further stimulus -> expired never asserts; registers hold defaults. Check time_left=0 when TIMER_STATUS_EN is defined.
